conv_output_streamer: RTL and testbench

CONV_OUTPUT_STREAMER -- requirements
Module: conv_output_streamer

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_index_counter.sv | 57 +++++
 rtl/conv_output_streamer.sv | 121 ++++++++++++
 tb/tb_conv_output_streamer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv output streamer: word width, output-edge math, FSM states.
package conv_pkg;

   localparam int unsigned WordW = 32;

   typedef enum logic {
      StIdle,
      StStream
   } state_t;

   function automatic int unsigned calc_out_dim(int unsigned in_size, int unsigned filt_size,
                                                int unsigned step);
      return ((in_size - filt_size) / step) + 1;
   endfunction

   // Index width for a counter over n values, never narrower than one bit.
   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_index_counter.sv
// Filter/row/col position counter for the streamer; col is innermost, filter outermost.
module conv_index_counter
   import conv_pkg::*;
#(
   parameter int unsigned num_filters = 16,
   parameter int unsigned out_dim     = 11,
   parameter int unsigned FiltW       = idx_width(num_filters),
   parameter int unsigned PosW        = idx_width(out_dim)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_advance,
   output logic [FiltW-1:0] o_filter,
   output logic [PosW-1:0]  o_row,
   output logic [PosW-1:0]  o_col,
   output logic             o_last
);

   logic [FiltW-1:0] r_filter;
   logic [PosW-1:0]  r_row;
   logic [PosW-1:0]  r_col;
   logic             w_col_end;
   logic             w_row_end;
   logic             w_filt_end;

   assign w_col_end  = (r_col == PosW'(out_dim - 1));
   assign w_row_end  = (r_row == PosW'(out_dim - 1));
   assign w_filt_end = (r_filter == FiltW'(num_filters - 1));

   // Accepting the last word wraps every counter back to zero for the next snapshot.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_filter <= '0;
         r_row    <= '0;
         r_col    <= '0;
      end else if (i_advance) begin
         if (w_col_end) begin
            r_col <= '0;
            if (w_row_end) begin
               r_row    <= '0;
               r_filter <= w_filt_end ? '0 : r_filter + 1'b1;
            end else begin
               r_row <= r_row + 1'b1;
            end
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_filter = r_filter;
   assign o_row    = r_row;
   assign o_col    = r_col;
   assign o_last   = w_col_end && w_row_end && w_filt_end;

endmodule

// File: rtl/conv_output_streamer.sv
// Snapshots a packed conv result and streams it word by word (word k at bits [k*32 +: 32]).
// Optional CONV_STREAM_RELU_EN clamps negative buffered words to zero on output.
module conv_output_streamer
   import conv_pkg::*;
#(
   parameter int unsigned num_filters = 16,
   parameter int unsigned input_size  = 28,
   parameter int unsigned filter_size = 7,
   parameter int unsigned stride      = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic [num_filters*calc_out_dim(input_size, filter_size, stride)*
                 calc_out_dim(input_size, filter_size, stride)*WordW-1:0] conv_layer_output,
   output logic busy,
   output logic out_valid,
   input  logic out_ready,
   output logic [WordW-1:0] out_data,
   output logic [idx_width(num_filters)-1:0] out_filter,
   output logic [idx_width(calc_out_dim(input_size, filter_size, stride))-1:0] out_row,
   output logic [idx_width(calc_out_dim(input_size, filter_size, stride))-1:0] out_col,
   output logic out_last
);

   localparam int unsigned OutDim     = calc_out_dim(input_size, filter_size, stride);
   localparam int unsigned PlaneWords = OutDim * OutDim;
   localparam int unsigned TotalWords = num_filters * PlaneWords;
   localparam int unsigned FiltW      = idx_width(num_filters);
   localparam int unsigned PosW       = idx_width(OutDim);
   localparam int unsigned AddrW      = idx_width(TotalWords);

   state_t           r_state;
   state_t           w_state_next;
   logic [WordW-1:0] r_buf [TotalWords];
   logic             w_streaming;
   logic             w_load;
   logic             w_accept;
   logic [FiltW-1:0] w_filter;
   logic [PosW-1:0]  w_row;
   logic [PosW-1:0]  w_col;
   logic             w_last;
   logic [AddrW-1:0] w_addr;
   logic [WordW-1:0] w_raw;
   logic [WordW-1:0] w_word;

   assign w_streaming = (r_state == StStream);
   assign w_load      = (r_state == StIdle) && start;
   assign w_accept    = w_streaming && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:   if (start) w_state_next = StStream;
         StStream: if (out_ready && w_last) w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   // Buffer only loads from IDLE, so it is frozen for the whole stream; no reset needed.
   always_ff @(posedge clk) begin
      if (w_load) begin
         for (int k = 0; k < int'(TotalWords); k++) begin
            r_buf[k] <= conv_layer_output[k*WordW +: WordW];
         end
      end
   end

   conv_index_counter #(
      .num_filters (num_filters),
      .out_dim     (OutDim),
      .FiltW       (FiltW),
      .PosW        (PosW)
   ) u_index_counter (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_clear   (w_load),
      .i_advance (w_accept),
      .o_filter  (w_filter),
      .o_row     (w_row),
      .o_col     (w_col),
      .o_last    (w_last)
   );

   assign w_addr = AddrW'(w_filter) * AddrW'(PlaneWords)
                 + AddrW'(w_row) * AddrW'(OutDim)
                 + AddrW'(w_col);
   assign w_raw  = r_buf[w_addr];

`ifdef CONV_STREAM_RELU_EN
   assign w_word = w_raw[WordW-1] ? '0 : w_raw;
`else
   assign w_word = w_raw;
`endif

   always_comb begin
      busy       = w_streaming;
      out_valid  = w_streaming;
      out_data   = '0;
      out_filter = '0;
      out_row    = '0;
      out_col    = '0;
      out_last   = 1'b0;
      if (w_streaming) begin
         out_data   = w_word;
         out_filter = w_filter;
         out_row    = w_row;
         out_col    = w_col;
         out_last   = w_last;
      end
   end

endmodule

// File: tb/tb_conv_output_streamer.sv
// Directed bench for conv_output_streamer: 2 filters, out_dim 2, 8 words per snapshot.
module tb_conv_output_streamer;

   localparam int NW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            out_ready;
   logic [NW*32-1:0] conv_layer_output;
   logic            busy;
   logic            out_valid;
   logic [31:0]     out_data;
   logic [0:0]      out_filter;
   logic [0:0]      out_row;
   logic [0:0]      out_col;
   logic            out_last;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   conv_output_streamer #(
      .num_filters (2),
      .input_size  (5),
      .filter_size (3),
      .stride      (2)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .conv_layer_output (conv_layer_output),
      .busy              (busy),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_filter        (out_filter),
      .out_row           (out_row),
      .out_col           (out_col),
      .out_last          (out_last)
   );

   task automatic load_seq();
      for (int k = 0; k < NW; k++) conv_layer_output[k*32 +: 32] = 32'(k + 1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 ||
          out_filter !== 1'b0 || out_row !== 1'b0 || out_col !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: busy=%b valid=%b data=%h last=%b f/r/c=%b%b%b, want all 0",
                  busy, out_valid, out_data, out_last, out_filter, out_row, out_col);
      end
      rst = 1'b0; start = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_over_start: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_stream();
      logic [0:0] ef, er, ec;
      load_seq();
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NW; i++) begin
         ef = 1'(i / 4); er = 1'((i / 2) % 2); ec = 1'(i % 2);
         n_checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 32'(i + 1) ||
             out_filter !== ef || out_row !== er || out_col !== ec ||
             out_last !== (i == NW - 1)) begin
            n_errors++;
            $display("FAIL stream_word%0d: valid=%b busy=%b data=%h f/r/c=%b%b%b last=%b, want 1 1 %h %b%b%b %b",
                     i, out_valid, busy, out_data, out_filter, out_row, out_col, out_last,
                     32'(i + 1), ef, er, ec, (i == NW - 1));
         end
         @(negedge clk);
      end
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
         n_errors++;
         $display("FAIL stream_end: busy=%b valid=%b data=%h last=%b, want 0 0 0 0",
                  busy, out_valid, out_data, out_last);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] pat = 4'b1001;
      logic       rdy;
      int         idx = 0;
      load_seq();
      start = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 40 && idx < NW; cyc++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 32'(idx + 1) || out_last !== (idx == NW - 1)) begin
            n_errors++;
            $display("FAIL stall_cycle%0d: valid=%b data=%h last=%b, want 1 %h %b",
                     cyc, out_valid, out_data, out_last, 32'(idx + 1), (idx == NW - 1));
         end
         rdy = pat[cyc % 4];
         out_ready = rdy;
         @(negedge clk);
         if (rdy) idx++;
      end
      n_checks++;
      if (idx != NW || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_end: accepted=%0d busy=%b, want %0d 0", idx, busy, NW);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_snapshot();
      load_seq();
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NW; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 32'(i + 1)) begin
            n_errors++;
            $display("FAIL snapshot_word%0d: valid=%b data=%h, want 1 %h",
                     i, out_valid, out_data, 32'(i + 1));
         end
         if (i == 0) begin
            for (int k = 0; k < NW; k++) conv_layer_output[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL snapshot_end: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      load_seq();
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      n_checks++;
      if (out_data !== 32'd4) begin
         n_errors++;
         $display("FAIL mid_pre_reset: data=%h, want 00000004", out_data);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 ||
          out_filter !== 1'b0 || out_row !== 1'b0 || out_col !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_reset: busy=%b valid=%b data=%h last=%b f/r/c=%b%b%b, want all 0",
                  busy, out_valid, out_data, out_last, out_filter, out_row, out_col);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NW; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 32'(i + 1)) begin
            n_errors++;
            $display("FAIL restart_word%0d: valid=%b data=%h, want 1 %h",
                     i, out_valid, out_data, 32'(i + 1));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_relu();
      logic [31:0] exp;
      load_seq();
      conv_layer_output[2*32 +: 32] = 32'hFFFF_FFF6;
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NW; i++) begin
         exp = 32'(i + 1);
`ifdef CONV_STREAM_RELU_EN
         if (i == 2) exp = 32'h0;
`else
         if (i == 2) exp = 32'hFFFF_FFF6;
`endif
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp) begin
            n_errors++;
            $display("FAIL relu_word%0d: valid=%b data=%h, want 1 %h", i, out_valid, out_data, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      load_seq();
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NW; i++) begin
         if (i == NW - 1) start = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_start_on_last: busy=%b valid=%b, want 0 0", busy, out_valid);
      end
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NW; i++) begin
         n_checks++;
         if (busy !== 1'b1 || out_data !== 32'(i + 1)) begin
            n_errors++;
            $display("FAIL b2b_word%0d: busy=%b data=%h, want 1 %h", i, busy, out_data, 32'(i + 1));
         end
         @(negedge clk);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_end: busy=%b, want 0", busy);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      conv_layer_output = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_snapshot();
      test_reset_mid();
      test_relu();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
